// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_arb_pkg;

  localparam int REG_AW           = 5;
  localparam int DATA_W           = 32;
  localparam int MAX_WAIT_DEFAULT = 4;

  // Which requester owns the write port this cycle.
  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_PIPE,
    GNT_HOLD
  } gnt_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Busy bitmap of registers with an outstanding multi-cycle write.
// Instantiated by wb_port_arbiter only when WBARB_SCOREBOARD_EN is defined.
module wb_scoreboard
  import wb_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              set_v,
  input  logic [REG_AW-1:0] set_wa,
  input  logic              clr_v,
  input  logic [REG_AW-1:0] clr_wa,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic              busy1,
  output logic              busy2
);

  logic [31:0] busy_d, busy_q;

  // Clear on holding grant, then set on issue so a same-register set wins.
  always_comb begin
    // NOTE: busy_d starts from busy_q before any conditional write, so every
    // path assigns it and no latch is inferred.
    busy_d = busy_q;
    if (clr_v) busy_d[clr_wa] = 1'b0;
    if (set_v && (set_wa != '0)) busy_d[set_wa] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Bitmap register, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy1 = busy_q[ra1];
  assign busy2 = busy_q[ra2];

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the in-order writeback stage
// (priority, never waits) and a one-entry holding register fed by the
// multi-cycle unit. A starvation counter raises stall_req so a held write
// always drains. Optional busy scoreboard: define WBARB_SCOREBOARD_EN.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT,
  parameter int unsigned CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_we,
  input  logic [REG_AW-1:0] pipe_wa,
  input  logic [DATA_W-1:0] pipe_wd,
  input  logic              mc_valid,
  output logic              mc_ready,
  input  logic [REG_AW-1:0] mc_wa,
  input  logic [DATA_W-1:0] mc_wd,
  output logic              stall_req,
  output logic              we3,
  output logic [REG_AW-1:0] wa3,
  output logic [DATA_W-1:0] wd3,
`ifdef WBARB_SCOREBOARD_EN
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_wa,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic              busy1,
  output logic              busy2,
`endif
  output logic              pipe_drop
);

  localparam logic [CNT_W:0] MAX_WAIT_C = (CNT_W + 1)'(MAX_WAIT);

  logic              hold_v_d, hold_v_q;
  logic [REG_AW-1:0] hold_wa_d, hold_wa_q;
  logic [DATA_W-1:0] hold_wd_d, hold_wd_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              stall_d, stall_q;
  logic              drop_d, drop_q;

  gnt_e gnt;
  logic pw;
  logic hold_gnt;
  logic capture;
  logic wait_exp;

  assign pw       = pipe_we & (pipe_wa != '0);
  assign mc_ready = ~hold_v_q;
  assign capture  = mc_valid & mc_ready & (mc_wa != '0);
  assign hold_gnt = (gnt == GNT_HOLD);
  assign wait_exp = ({1'b0, cnt_q} + (CNT_W + 1)'(1)) >= MAX_WAIT_C;

  // Grant selection; a pending entry being reset never reaches the port.
  always_comb begin
    gnt = GNT_NONE;
    if (!rst) begin
      if (stall_q && hold_v_q) gnt = GNT_HOLD;
      else if (pw)             gnt = GNT_PIPE;
      else if (hold_v_q)       gnt = GNT_HOLD;
    end
  end

  // Write-port mux driven by the grant.
  always_comb begin
    we3 = 1'b0;
    wa3 = '0;
    wd3 = '0;
    case (gnt)
      GNT_PIPE: begin we3 = 1'b1; wa3 = pipe_wa;   wd3 = pipe_wd;   end
      GNT_HOLD: begin we3 = 1'b1; wa3 = hold_wa_q; wd3 = hold_wd_q; end
      default:  ;
    endcase
  end

  // Next state for the holding entry, starvation counter and status flags.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' so later statements see
    // earlier results; the registers below use non-blocking '<='.
    hold_v_d  = hold_v_q;
    hold_wa_d = hold_wa_q;
    hold_wd_d = hold_wd_q;
    if (hold_gnt) hold_v_d = 1'b0;
    if (capture) begin
      hold_v_d  = 1'b1;
      hold_wa_d = mc_wa;
      hold_wd_d = mc_wd;
    end
    cnt_d   = (hold_v_q && !hold_gnt) ? cnt_q + CNT_W'(1) : '0;
    stall_d = wait_exp & hold_v_q & ~hold_gnt;
    drop_d  = drop_q | (pipe_we & stall_q);
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v_q <= 1'b0;
      cnt_q    <= '0;
      stall_q  <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      hold_v_q <= hold_v_d;
      cnt_q    <= cnt_d;
      stall_q  <= stall_d;
      drop_q   <= drop_d;
    end
  end

  // Holding payload.
  always_ff @(posedge clk) begin
    // NOTE: payload registers are not reset; hold_v_q qualifies them, so their
    // contents are irrelevant until a capture loads them.
    hold_wa_q <= hold_wa_d;
    hold_wd_q <= hold_wd_d;
  end

  assign stall_req = stall_q;
  assign pipe_drop = drop_q;

`ifdef WBARB_SCOREBOARD_EN
  wb_scoreboard u_scoreboard (
    .clk    (clk),
    .rst    (rst),
    .set_v  (issue_valid),
    .set_wa (issue_wa),
    .clr_v  (hold_gnt),
    .clr_wa (hold_wa_q),
    .ra1    (ra1),
    .ra2    (ra2),
    .busy1  (busy1),
    .busy2  (busy2)
  );
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter. Expected port writes are queued
// as stimulus is driven and compared by a negedge monitor; each scenario task
// also compares handshake and status outputs inline.
module tb_wb_port_arbiter;
  import wb_arb_pkg::*;

  typedef struct packed {
    logic [REG_AW-1:0] wa;
    logic [DATA_W-1:0] wd;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pipe_we = 1'b0;
  logic [REG_AW-1:0] pipe_wa = '0;
  logic [DATA_W-1:0] pipe_wd = '0;
  logic              mc_valid = 1'b0;
  logic              mc_ready;
  logic [REG_AW-1:0] mc_wa = '0;
  logic [DATA_W-1:0] mc_wd = '0;
  logic              stall_req;
  logic              we3;
  logic [REG_AW-1:0] wa3;
  logic [DATA_W-1:0] wd3;
  logic              pipe_drop;
`ifdef WBARB_SCOREBOARD_EN
  logic              issue_valid = 1'b0;
  logic [REG_AW-1:0] issue_wa = '0;
  logic [REG_AW-1:0] ra1 = '0;
  logic [REG_AW-1:0] ra2 = '0;
  logic              busy1, busy2;
`endif

  int  errors = 0;
  int  checks = 0;
  wr_t exp_q[$];

  wb_port_arbiter #(.MAX_WAIT(4), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .pipe_we   (pipe_we),
    .pipe_wa   (pipe_wa),
    .pipe_wd   (pipe_wd),
    .mc_valid  (mc_valid),
    .mc_ready  (mc_ready),
    .mc_wa     (mc_wa),
    .mc_wd     (mc_wd),
    .stall_req (stall_req),
    .we3       (we3),
    .wa3       (wa3),
    .wd3       (wd3),
`ifdef WBARB_SCOREBOARD_EN
    .issue_valid (issue_valid),
    .issue_wa    (issue_wa),
    .ra1         (ra1),
    .ra2         (ra2),
    .busy1       (busy1),
    .busy2       (busy2),
`endif
    .pipe_drop (pipe_drop)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: every port write must match the oldest expectation.
  always @(negedge clk) begin
    if (we3 === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL port_write: unexpected write wa3=%0d wd3=%h", wa3, wd3);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (wa3 !== e.wa || wd3 !== e.wd) begin
          errors++;
          $display("FAIL port_write: got wa3=%0d wd3=%h expected wa3=%0d wd3=%h",
                   wa3, wd3, e.wa, e.wd);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pipe(input logic we, input logic [4:0] wa, input logic [31:0] wd);
    pipe_we = we;
    pipe_wa = wa;
    pipe_wd = wd;
  endtask

  task automatic drive_mc(input logic v, input logic [4:0] wa, input logic [31:0] wd);
    mc_valid = v;
    mc_wa    = wa;
    mc_wd    = wd;
  endtask

  task automatic expect_write(input logic [4:0] wa, input logic [31:0] wd);
    wr_t e;
    e.wa = wa;
    e.wd = wd;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (we3 !== 1'b0)       begin errors++; $display("FAIL reset_we3: got %b expected 0", we3); end
    checks++; if (mc_ready !== 1'b1)  begin errors++; $display("FAIL reset_mc_ready: got %b expected 1", mc_ready); end
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall_req: got %b expected 0", stall_req); end
    checks++; if (pipe_drop !== 1'b0) begin errors++; $display("FAIL reset_pipe_drop: got %b expected 0", pipe_drop); end
    next_cycle();
  endtask

  task automatic test_pipe_write();
    drive_pipe(1'b1, 5'd5, 32'h1234);
    expect_write(5'd5, 32'h1234);
    @(negedge clk);
    checks++; if (we3 !== 1'b1) begin errors++; $display("FAIL pipe_same_cycle_we3: got %b expected 1", we3); end
    next_cycle();
    drive_pipe(1'b1, 5'd0, 32'hFFFF);
    @(negedge clk);
    checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL pipe_r0_we3: got %b expected 0", we3); end
    next_cycle();
    drive_pipe(1'b0, 5'd0, 32'h0);
    // A multi-cycle result aimed at $0 is accepted and dropped.
    drive_mc(1'b1, 5'd0, 32'h5555);
    @(negedge clk);
    checks++; if (mc_ready !== 1'b1) begin errors++; $display("FAIL mc_r0_ready_before: got %b expected 1", mc_ready); end
    next_cycle();
    drive_mc(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    checks++; if (mc_ready !== 1'b1) begin errors++; $display("FAIL mc_r0_discard_ready: got %b expected 1", mc_ready); end
    checks++; if (we3 !== 1'b0)      begin errors++; $display("FAIL mc_r0_discard_we3: got %b expected 0", we3); end
    next_cycle();
  endtask

  task automatic test_conflict();
    drive_mc(1'b1, 5'd8, 32'hDEAD);
    @(negedge clk);
    checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL conflict_no_bypass: got we3=%b expected 0", we3); end
    next_cycle();
    drive_mc(1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      drive_pipe(1'b1, 5'd3, 32'h3000 + i);
      expect_write(5'd3, 32'h3000 + i);
      @(negedge clk);
      checks++; if (mc_ready !== 1'b0) begin errors++; $display("FAIL conflict_hold_pending: got mc_ready=%b expected 0", mc_ready); end
      next_cycle();
    end
    drive_pipe(1'b0, 5'd0, 32'h0);
    expect_write(5'd8, 32'hDEAD);
    @(negedge clk);
    checks++; if (wa3 !== 5'd8) begin errors++; $display("FAIL conflict_hold_grant: got wa3=%0d expected 8", wa3); end
    next_cycle();
    @(negedge clk);
    checks++; if (mc_ready !== 1'b1) begin errors++; $display("FAIL conflict_ready_after: got %b expected 1", mc_ready); end
    checks++; if (we3 !== 1'b0)      begin errors++; $display("FAIL conflict_idle_we3: got %b expected 0", we3); end
    next_cycle();
  endtask

  // Capture a held write while the pipeline writes continuously; keep_pipe
  // decides whether the pipeline also ignores the stall request.
  task automatic starve(input logic keep_pipe, input logic [4:0] hwa, input logic [31:0] hwd);
    drive_mc(1'b1, hwa, hwd);
    drive_pipe(1'b1, 5'd4, 32'h400);
    expect_write(5'd4, 32'h400);
    @(negedge clk);
    next_cycle();
    drive_mc(1'b0, 5'd0, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      drive_pipe(1'b1, 5'd4, 32'h400 + i);
      expect_write(5'd4, 32'h400 + i);
      @(negedge clk);
      checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL starve_no_stall_%0d: got %b expected 0", i, stall_req); end
      next_cycle();
    end
    drive_pipe(keep_pipe, 5'd4, 32'h4FF);
    expect_write(hwa, hwd);
    @(negedge clk);
    checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL starve_stall: got %b expected 1", stall_req); end
    checks++; if (pipe_drop !== 1'b0) begin errors++; $display("FAIL starve_drop_lag: got %b expected 0", pipe_drop); end
    next_cycle();
    drive_pipe(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL starve_stall_drop: got %b expected 0", stall_req); end
    checks++; if (mc_ready !== 1'b1)  begin errors++; $display("FAIL starve_ready: got %b expected 1", mc_ready); end
    checks++; if (pipe_drop !== keep_pipe) begin errors++; $display("FAIL starve_pipe_drop: got %b expected %b", pipe_drop, keep_pipe); end
    next_cycle();
  endtask

  task automatic test_starvation();
    starve(1'b0, 5'd10, 32'hA0A0);
  endtask

  task automatic test_pipe_drop();
    starve(1'b1, 5'd11, 32'hB0B0);
    repeat (3) next_cycle();
    @(negedge clk);
    checks++; if (pipe_drop !== 1'b1) begin errors++; $display("FAIL drop_sticky: got %b expected 1", pipe_drop); end
    next_cycle();
  endtask

  task automatic test_reset_midop();
    drive_mc(1'b1, 5'd12, 32'hC0C0);
    @(negedge clk);
    next_cycle();
    drive_mc(1'b0, 5'd0, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL midop_rst_we3: got %b expected 0", we3); end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (we3 !== 1'b0)       begin errors++; $display("FAIL midop_after_we3: got %b expected 0", we3); end
    checks++; if (mc_ready !== 1'b1)  begin errors++; $display("FAIL midop_ready: got %b expected 1", mc_ready); end
    checks++; if (pipe_drop !== 1'b0) begin errors++; $display("FAIL midop_drop_clr: got %b expected 0", pipe_drop); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    // Two mc results offered continuously; each takes two cycles.
    drive_mc(1'b1, 5'd20, 32'h2020);
    @(negedge clk);
    next_cycle();
    drive_mc(1'b1, 5'd21, 32'h2121);
    expect_write(5'd20, 32'h2020);
    @(negedge clk);
    checks++; if (mc_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_low: got %b expected 0", mc_ready); end
    next_cycle();
    @(negedge clk);
    checks++; if (mc_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_high: got %b expected 1", mc_ready); end
    next_cycle();
    drive_mc(1'b0, 5'd0, 32'h0);
    expect_write(5'd21, 32'h2121);
    @(negedge clk);
    next_cycle();
  endtask

`ifdef WBARB_SCOREBOARD_EN
  task automatic test_scoreboard();
    issue_valid = 1'b1; issue_wa = 5'd9;
    next_cycle();
    issue_valid = 1'b1; issue_wa = 5'd0;
    ra1 = 5'd9; ra2 = 5'd0;
    drive_mc(1'b1, 5'd9, 32'h9999);
    @(negedge clk);
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL sb_busy_set: got %b expected 1", busy1); end
    next_cycle();
    issue_valid = 1'b0;
    drive_mc(1'b0, 5'd0, 32'h0);
    expect_write(5'd9, 32'h9999);
    @(negedge clk);
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL sb_r0_zero: got %b expected 0", busy2); end
    next_cycle();
    drive_mc(1'b1, 5'd9, 32'h9A9A);
    @(negedge clk);
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL sb_busy_clear: got %b expected 0", busy1); end
    next_cycle();
    drive_mc(1'b0, 5'd0, 32'h0);
    issue_valid = 1'b1; issue_wa = 5'd9;
    expect_write(5'd9, 32'h9A9A);
    @(negedge clk);
    next_cycle();
    issue_valid = 1'b0;
    @(negedge clk);
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL sb_set_wins: got %b expected 1", busy1); end
    next_cycle();
  endtask
`endif

  initial begin
    test_reset();
    test_pipe_write();
    test_conflict();
    test_starvation();
    test_pipe_drop();
    test_reset_midop();
    test_back_to_back();
`ifdef WBARB_SCOREBOARD_EN
    test_scoreboard();
`endif
    repeat (2) next_cycle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected writes never appeared, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port (we3/wa3/wd3) between two requesters.
- Requester 1 is the in-order pipeline writeback stage, which has priority and never waits.
- Requester 2 is the multi-cycle unit (mul/div, uncached load return). It uses a valid/ready handshake into a one-entry holding register.
- A starvation counter forces a pipeline stall so the held write is guaranteed to drain.

Parameters:
MAX_WAIT, 4, cycles the holding entry may be denied before stall_req asserts (1..15)
CNT_W, 4, starvation counter width; must satisfy 2^CNT_W > MAX_WAIT

Ports:
clk  input  1  clock, rising-edge logic (regfile writes on negedge of same clk)
rst  input  1  synchronous active-high reset
pipe_we  input  1  pipeline writeback valid
pipe_wa  input  5  pipeline destination register
pipe_wd  input  32  pipeline write data
mc_valid  input  1  multi-cycle result valid
mc_ready  output  1  holding register empty, can accept
mc_wa  input  5  multi-cycle destination register
mc_wd  input  32  multi-cycle write data
stall_req  output  1  registered; pipeline must hold WB (pipe_we=0) next cycle
we3  output  1  regfile write enable
wa3  output  5  regfile write address
wd3  output  32  regfile write data
pipe_drop  output  1  sticky error: pipe_we=1 while stall_req=1
issue_valid  input  1  [WBARB_SCOREBOARD_EN] multi-cycle op issued
issue_wa  input  5  [WBARB_SCOREBOARD_EN] its destination
ra1, ra2  input  5  [WBARB_SCOREBOARD_EN] decode read addresses
busy1, busy2  output  1  [WBARB_SCOREBOARD_EN] source has outstanding multi-cycle write

Behaviour:
- Reset (sync, rst=1 at posedge):
  - hold_v=0, cnt=0, stall_req=0, pipe_drop=0, scoreboard=0.
  - Hence mc_ready=1, we3=0.
- Handshake:
  - mc_ready = ~hold_v, purely from state, not from mc_valid.
  - Capture happens at posedge when mc_valid & mc_ready. It loads hold_wa/hold_wd and sets hold_v.
  - Captures with mc_wa=0 are accepted and discarded; hold_v stays 0.
- Grant is combinational, evaluated each cycle:
  - pw = pipe_we & (pipe_wa != 0). Writes to $0 never reach the port.
  - If stall_req=1 and hold_v: grant holding.
  - Else if pw: grant pipeline.
  - Else if hold_v: grant holding.
  - Else: we3=0, wa3=0, wd3=0.
- Latency: a pipeline write appears on we3 in the same cycle. A holding write appears no earlier than the cycle after capture; there is no same-cycle bypass from mc_* to the port.
- Holding granted: hold_v clears at posedge. mc_ready rises the next cycle, so back-to-back mc results need at least 2 cycles each.
- Starvation counter:
  - cnt increments each cycle hold_v=1 and the holding entry is not granted.
  - cnt resets to 0 on holding grant or when hold_v=0.
  - stall_req <= (cnt+1 >= MAX_WAIT) & hold_v & ~holding_granted, registered.
  - While stall_req=1 the holding entry wins unconditionally. stall_req drops the cycle after that grant.
  - Worst-case wait is therefore MAX_WAIT+1 cycles.
- Illegal stall overlap: pipe_we=1 while stall_req=1 means the pipeline write is lost, not written. pipe_drop sets and stays set until rst.
- Reset mid-operation: a pending holding entry is discarded, with no write issued.

Optional Feature:
WBARB_SCOREBOARD_EN
- Defined:
  - A 32-bit busy bitmap is maintained.
  - issue_valid with issue_wa != 0 sets bit issue_wa at posedge.
  - A holding-register grant clears bit hold_wa.
  - If the set and the clear target the same register in the same cycle, the set wins.
  - busy1 = busy[ra1], busy2 = busy[ra2], combinational. Bit 0 always reads 0.
- Undefined: the issue/ra/busy ports are absent and the bitmap logic is not generated.

Decomposition:
- Shared package wb_arb_pkg holds:
  - REG_AW=5 and DATA_W=32.
  - the grant-source enum {GNT_NONE, GNT_PIPE, GNT_HOLD}.
  - the default MAX_WAIT constant.
- One natural sub-module, wb_scoreboard, holds the busy bitmap. It is instantiated only under WBARB_SCOREBOARD_EN.

Test Plan:
- rst=1 for 2 cycles, then idle -> we3=0, mc_ready=1, stall_req=0, pipe_drop=0.
- Write from the pipeline only:
  - pipe_we=1, wa=5, wd=0x1234 -> same cycle we3=1, wa3=5, wd3=0x1234.
  - pipe_wa=0 -> we3=0.
- Conflict: mc captures wa=8, wd=0xDEAD at cycle 0, and pipe_we=1 (wa=3) on cycles 1-2.
  - cycles 1-2 -> port carries wa=3; hold stays pending.
  - cycle 3, pipe idle -> wa3=8, wd3=0xDEAD; mc_ready=1 at cycle 4.
- Starvation with MAX_WAIT=4 and pipe_we held high -> stall_req=1 after the 4th denied cycle; the next cycle grants hold; stall_req=0 the following cycle.
- Keeping pipe_we=1 during stall_req -> pipe_drop=1 and remains 1 until rst.
- With WBARB_SCOREBOARD_EN:
  - issue_wa=9, then ra1=9 -> busy1=1.
  - Held wa=9 written -> busy1=0 next cycle.
  - Simultaneous re-issue of wa=9 -> busy1 stays 1.
